// File: rtl/ccg_sweep_ctrl_if.sv
// Harness-side bus of ccg_sweep_ctrl: sweep control, CUT vector/response and result status.
// Optional golden compare ports appear when CCG_SWEEP_GOLDEN_CMP_EN is defined.
interface ccg_sweep_ctrl_if #(
   parameter int N_IN  = 11,
   parameter int N_OUT = 13,
   parameter int SIG_W = 16
);
   logic              start;
   logic              abort;
   logic              pause;
   logic [N_IN-1:0]   cut_in;
   logic [N_OUT-1:0]  cut_out;
   logic              busy;
   logic              done;
   logic [SIG_W-1:0]  signature;
   logic [N_IN:0]     onset_cnt;
   logic [N_IN:0]     vec_idx;
`ifdef CCG_SWEEP_GOLDEN_CMP_EN
   logic [SIG_W-1:0]  golden_sig;
   logic              pass;
   logic              fail;
`endif

   modport master (
      output start, abort, pause, cut_out,
`ifdef CCG_SWEEP_GOLDEN_CMP_EN
      output golden_sig,
      input  pass, fail,
`endif
      input  cut_in, busy, done, signature, onset_cnt, vec_idx
   );

   modport slave (
      input  start, abort, pause, cut_out,
`ifdef CCG_SWEEP_GOLDEN_CMP_EN
      input  golden_sig,
      output pass, fail,
`endif
      output cut_in, busy, done, signature, onset_cnt, vec_idx
   );
endinterface

// File: rtl/ccg_sweep_ctrl.sv
// Exhaustive CUT input sweeper with MISR signature and onset counter.
// Optional signature compare against golden_sig: define CCG_SWEEP_GOLDEN_CMP_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start, results of last sweep held
// S_DRIVE   | present vector v on cut_in
// S_SETTLE  | wait SETTLE_CYC cycles for the CUT to settle
// S_CAPTURE | fold cut_out into MISR/onset, advance v
// S_DONE    | all 2^N_IN vectors captured, results held
module ccg_sweep_ctrl #(
   parameter int               N_IN       = 11,
   parameter int               N_OUT      = 13,
   parameter int               SIG_W      = 16,
   parameter int               SETTLE_CYC = 1,
   parameter logic [SIG_W-1:0] SEED       = SIG_W'(16'hFFFF)
) (
   input  logic            clk,
   input  logic            rst,
   ccg_sweep_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_DRIVE, S_SETTLE, S_CAPTURE, S_DONE
   } state_t;

   localparam logic [SIG_W-1:0] POLY      = SIG_W'(16'h1021);
   localparam logic [7:0]       SETTLE_LD = (SETTLE_CYC > 0) ? 8'(SETTLE_CYC - 1) : 8'd0;

   state_t            state, state_nxt;
   logic [N_IN-1:0]   v;
   logic [N_IN-1:0]   cut_in_q;
   logic [7:0]        settle_cnt;
   logic [SIG_W-1:0]  sig_q, sig_nxt;
   logic [N_IN:0]     onset_q, vidx_q;
   logic              load_run, do_drive, do_capture, settle_load, settle_dec;
   logic              last_vec;

   assign last_vec = (v == {N_IN{1'b1}});
   assign sig_nxt  = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(bus.cut_out);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      load_run    = 1'b0;
      do_drive    = 1'b0;
      do_capture  = 1'b0;
      settle_load = 1'b0;
      settle_dec  = 1'b0;
      if (bus.abort) begin
         state_nxt = S_IDLE;
      end else if (!bus.pause) begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state_nxt = S_DRIVE;
                  load_run  = 1'b1;
               end
            end
            S_DRIVE: begin
               do_drive = 1'b1;
               if (SETTLE_CYC > 0) begin
                  state_nxt   = S_SETTLE;
                  settle_load = 1'b1;
               end else begin
                  state_nxt = S_CAPTURE;
               end
            end
            S_SETTLE: begin
               if (settle_cnt == 8'd0) state_nxt = S_CAPTURE;
               else                    settle_dec = 1'b1;
            end
            S_CAPTURE: begin
               do_capture = 1'b1;
               state_nxt  = last_vec ? S_DONE : S_DRIVE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v          <= '0;
         cut_in_q   <= '0;
         settle_cnt <= 8'd0;
         sig_q      <= SEED;
         onset_q    <= '0;
         vidx_q     <= '0;
      end else begin
         if (load_run) begin
            v       <= '0;
            sig_q   <= SEED;
            onset_q <= '0;
            vidx_q  <= '0;
         end
         if (do_drive) cut_in_q <= v;
         if (settle_load)     settle_cnt <= SETTLE_LD;
         else if (settle_dec) settle_cnt <= settle_cnt - 8'd1;
         // v stops at the last vector; vec_idx carries the extra bit for 2^N_IN
         if (do_capture) begin
            sig_q   <= sig_nxt;
            onset_q <= onset_q + {{N_IN{1'b0}}, bus.cut_out[0]};
            vidx_q  <= vidx_q + (N_IN+1)'(1);
            if (!last_vec) v <= v + N_IN'(1);
         end
      end
   end

`ifdef CCG_SWEEP_GOLDEN_CMP_EN
   logic pass_q, fail_q;

   always_ff @(posedge clk) begin
      if (rst || bus.abort || load_run) begin
         pass_q <= 1'b0;
         fail_q <= 1'b0;
      end else if (do_capture && last_vec) begin
         pass_q <= (sig_nxt == bus.golden_sig);
         fail_q <= (sig_nxt != bus.golden_sig);
      end
   end

   assign bus.pass = pass_q;
   assign bus.fail = fail_q;
`endif

   assign bus.cut_in    = cut_in_q;
   assign bus.busy      = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CAPTURE);
   assign bus.done      = (state == S_DONE);
   assign bus.signature = sig_q;
   assign bus.onset_cnt = onset_q;
   assign bus.vec_idx   = vidx_q;
endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// Scoreboard bench for ccg_sweep_ctrl: software MISR model, pause/abort/reset scenarios.
module tb_ccg_sweep_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ccg_sweep_ctrl_if #(.N_IN(11), .N_OUT(13), .SIG_W(16)) bus ();
   ccg_sweep_ctrl_if #(.N_IN(4),  .N_OUT(4),  .SIG_W(16)) bus_s ();

   ccg_sweep_ctrl #(.N_IN(11), .N_OUT(13), .SIG_W(16), .SETTLE_CYC(1), .SEED(16'hFFFF))
      dut (.clk(clk), .rst(rst), .bus(bus));
   ccg_sweep_ctrl #(.N_IN(4), .N_OUT(4), .SIG_W(16), .SETTLE_CYC(0), .SEED(16'h0000))
      dut_s (.clk(clk), .rst(rst), .bus(bus_s));

   typedef struct {
      logic [15:0] sig;
      int          onset;
      int          vec;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cut_mode = 0;
   logic [15:0] golden   = 16'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Two structurally different but equivalent netlists (orig/balanced), plus a stuck-at variant.
   function automatic logic [12:0] cut_fn(input int mode, input logic [10:0] x);
      logic [12:0] o;
      o = '0;
      if (mode == 0) o[0] = x[0];
      else if (mode != 1) begin
         for (int i = 0; i < 13; i++) begin
            if (mode == 3)
               o[i] = (x[i%11] & x[(i+7)%11]) ^ (x[(i+3)%11] & x[(i+7)%11]) ^ x[(i+1)%11];
            else
               o[i] = ((x[i%11] ^ x[(i+3)%11]) & x[(i+7)%11]) ^ x[(i+1)%11];
         end
         if (mode == 4) o[7] = 1'b0;
      end
      return o;
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [12:0] co);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {3'b000, co};
   endfunction

   task automatic model(input int mode, input int nvec, output logic [15:0] sig, output int onset);
      logic [12:0] co;
      sig   = 16'hFFFF;
      onset = 0;
      for (int k = 0; k < nvec; k++) begin
         co    = cut_fn(mode, 11'(k));
         onset += int'(co[0]);
         sig   = misr_step(sig, co);
      end
   endtask

   always_comb bus.cut_out = cut_fn(cut_mode, bus.cut_in);
   assign bus_s.cut_out = 4'h0;
`ifdef CCG_SWEEP_GOLDEN_CMP_EN
   always_comb bus.golden_sig = golden;
   assign bus_s.golden_sig = 16'h0000;
`endif

   task automatic check_reset(input string tag);
      check({tag, "_sig"},   bus.signature, 16'hFFFF);
      check({tag, "_onset"}, bus.onset_cnt, 0);
      check({tag, "_vec"},   bus.vec_idx, 0);
      check({tag, "_cutin"}, bus.cut_in, 0);
      check({tag, "_busy"},  bus.busy, 0);
      check({tag, "_done"},  bus.done, 0);
`ifdef CCG_SWEEP_GOLDEN_CMP_EN
      check({tag, "_pass"},  bus.pass, 0);
      check({tag, "_fail"},  bus.fail, 0);
`endif
   endtask

   // p1/p2: edge counts after which pause is held 50 cycles; abort_vec>0 aborts at that vec_idx.
   task automatic run_sweep(input string tag, input int mode, input int p1, input int p2,
                            input int abort_vec, input int flip, input int restart_at,
                            output logic [15:0] sig_o);
      exp_t e, g;
      int   n;
      bit   fin, abort_sent;
      e.vec = (abort_vec > 0) ? abort_vec : 2048;
      model(mode, e.vec, e.sig, e.onset);
      e.cyc = 6145 + ((p1 > 0) ? 50 : 0) + ((p2 > 0) ? 50 : 0);
      sb.push_back(e);
      golden   = e.sig ^ 16'(flip);
      cut_mode = mode;
      @(posedge clk); #1;
      bus.start = 1'b1;
      n = 0; fin = 0; abort_sent = 0;
      while (!fin) begin
         @(posedge clk); n++; #1;
         bus.start = (n == restart_at);
         bus.pause = (p1 > 0 && n >= p1 && n < p1 + 50) || (p2 > 0 && n >= p2 && n < p2 + 50);
`ifdef CCG_SWEEP_GOLDEN_CMP_EN
         if (n == 1) begin
            check({tag, "_pass_clr"}, bus.pass, 0);
            check({tag, "_fail_clr"}, bus.fail, 0);
         end
`endif
         if (abort_sent) begin
            bus.abort = 1'b0;
            fin = 1;
            g = sb.pop_front();
            check({tag, "_abort_busy"}, bus.busy, 0);
            check({tag, "_abort_done"}, bus.done, 0);
            check({tag, "_abort_vec"},  bus.vec_idx, g.vec);
            check({tag, "_abort_sig"},  bus.signature, g.sig);
            check({tag, "_abort_onset"}, bus.onset_cnt, g.onset);
         end else if (abort_vec > 0 && int'(bus.vec_idx) == abort_vec) begin
            bus.abort  = 1'b1;
            abort_sent = 1;
         end else if (bus.done) begin
            fin = 1;
            g = sb.pop_front();
            check({tag, "_sig"},   bus.signature, g.sig);
            check({tag, "_onset"}, bus.onset_cnt, g.onset);
            check({tag, "_vec"},   bus.vec_idx, g.vec);
            check({tag, "_cycles"}, n, g.cyc);
            check({tag, "_cutin"}, bus.cut_in, 11'h7FF);
            check({tag, "_busy"},  bus.busy, 0);
`ifdef CCG_SWEEP_GOLDEN_CMP_EN
            check({tag, "_pass"}, bus.pass, (flip == 0) ? 1 : 0);
            check({tag, "_fail"}, bus.fail, (flip != 0) ? 1 : 0);
`endif
         end else if (n > 20000) begin
            check({tag, "_timeout"}, n, 0);
            void'(sb.pop_front());
            fin = 1;
         end
      end
      bus.pause = 1'b0;
      bus.abort = 1'b0;
      sig_o = bus.signature;
   endtask

   initial begin
      logic [15:0] s0, s_orig, s_bal, s_stuck, s_tmp;
      int          n;
      bus.start = 0; bus.abort = 0; bus.pause = 0;
      bus_s.start = 0; bus_s.abort = 0; bus_s.pause = 0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;

      // Small instance: SEED=0, zero response, no settle cycles
      @(posedge clk); #1;
      bus_s.start = 1'b1;
      n = 0;
      do begin
         @(posedge clk); n++; #1;
         bus_s.start = 1'b0;
      end while (!bus_s.done && n < 200);
      check("small_cycles", n, 33);
      check("small_sig",    bus_s.signature, 16'h0000);
      check("small_vec",    bus_s.vec_idx, 16);
      check("small_onset",  bus_s.onset_cnt, 0);
`ifdef CCG_SWEEP_GOLDEN_CMP_EN
      check("small_pass", bus_s.pass, 1);
`endif

      run_sweep("stub",  0, 0, 0, 0, 0, 100, s0);
      check("stub_onset_abs", bus.onset_cnt, 1024);
      run_sweep("orig",  2, 0, 0, 0, 1, 0, s_orig);
      run_sweep("bal",   3, 32, 1503, 0, 0, 0, s_bal);
      check("bal_eq_orig", s_bal, s_orig);
      run_sweep("stuck", 4, 0, 0, 0, 0, 0, s_stuck);
      check("stuck_differs", (s_stuck != s_orig) ? 1 : 0, 1);
      run_sweep("abort", 2, 0, 0, 100, 0, 0, s_tmp);

      bus.start = 1'b1; bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.abort = 1'b0;
      check("start_abort_busy", bus.busy, 0);
      check("start_abort_vec",  bus.vec_idx, 100);

      run_sweep("after_abort", 2, 0, 0, 0, 0, 0, s_tmp);
      check("after_abort_eq", s_tmp, s_orig);

      @(posedge clk); #1;
      bus.start = 1'b1;
      repeat (500) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      check("mid_busy", bus.busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_reset("mid_reset");

      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ccg_sweep_ctrl.md
Name: ccg_sweep_ctrl

Overview:
- Exhaustive-stimulus sequencer and response compactor for one combinational generated benchmark circuit (CUT), for example an 11-input / 13-output AIG netlist.
- Walks every input vector 0..2^N_IN-1 into the CUT and waits a programmable settle time.
- Captures the CUT outputs into a MISR signature and an onset counter.
- Lets the bench or silicon harness characterise or compare netlist variants (original vs BALANCED) without storing truth tables.

Parameters:
- N_IN, 11, CUT input width (1..16).
- N_OUT, 13, CUT output width (1..SIG_W).
- SIG_W, 16, MISR width; feedback polynomial fixed at x^16+x^12+x^5+1 (mask 16'h1021).
- SETTLE_CYC, 1, idle cycles between driving a vector and capturing outputs (0..255).
- SEED, 16'hFFFF, MISR value loaded at start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a sweep; sampled in IDLE or DONE only.
- abort  in  1  terminate the sweep, highest priority after rst.
- pause  in  1  freeze the sequencer; all state is held.
- cut_in  out  N_IN  vector driven to the CUT.
- cut_out  in  N_OUT  CUT response.
- busy  out  1  high in DRIVE, SETTLE and CAPTURE.
- done  out  1  high in DONE.
- signature  out  SIG_W  MISR value.
- onset_cnt  out  N_IN+1  count of vectors with cut_out[0]==1.
- vec_idx  out  N_IN+1  vectors captured so far.

Behaviour:
- Reset: state=IDLE; cut_in=0, busy=0, done=0, signature=SEED, onset_cnt=0, vec_idx=0.
- States: IDLE, DRIVE, SETTLE, CAPTURE, DONE.
- IDLE/DONE, start=1: next state DRIVE; signature<=SEED, onset_cnt<=0, vec_idx<=0, internal vector counter v<=0.
- DRIVE (1 cycle): cut_in<=v; cut_in then holds until the next DRIVE. Next state is SETTLE if SETTLE_CYC>0, else CAPTURE.
- SETTLE: holds for exactly SETTLE_CYC cycles using an 8-bit down-counter, then goes to CAPTURE.
- CAPTURE (1 cycle), sampling cut_out:
  - signature <= {signature[SIG_W-2:0],0} ^ (signature[SIG_W-1] ? 16'h1021 : 0) ^ zero-extended cut_out.
  - onset_cnt += cut_out[0].
  - vec_idx += 1.
  - If v==2^N_IN-1, next state is DONE; else v+=1 and next state is DRIVE.
- Per-vector period is SETTLE_CYC+2 cycles. Start to done is 1 + 2^N_IN*(SETTLE_CYC+2) cycles.
- DONE: done=1 and busy=0; signature, onset_cnt and vec_idx are held until the next start.
- Priority each cycle: rst > abort > pause > normal transition.
- abort in any state: next state IDLE. Partial signature, onset_cnt and vec_idx are kept. done is not asserted. cut_in is held.
- pause=1: the state, all counters and cut_in are frozen. A CAPTURE under pause does not sample; it samples on the first cycle pause=0.
- start while busy is ignored.
- start and abort in the same cycle: abort wins and the state stays IDLE.
- Vector wrap: v never wraps. The terminal compare is on v==2^N_IN-1. vec_idx reaches exactly 2^N_IN at DONE; the extra bit exists to hold that value.
- Reset mid-sweep returns every output to its reset value on the next edge.

Optional Feature:
- Macro: CCG_SWEEP_GOLDEN_CMP_EN.
- Defined, added ports:
  - golden_sig in SIG_W, the expected signature.
  - pass out 1.
  - fail out 1.
- pass/fail are computed once on the DONE entry edge: pass=(signature==golden_sig), fail=~pass. Both are cleared by rst, abort or start.
- Undefined: these ports are absent and there is no compare logic.

Test Plan:
- N_IN=11, SETTLE_CYC=1, stub cut_out={13{0}} except cut_out[0]=cut_in[0]; pulse start -> done rises exactly 6145 cycles after start, onset_cnt=1024, vec_idx=2048.
- SEED=0, cut_out tied 0 -> signature=0 at DONE; with SEED=16'hFFFF -> signature matches the bench software MISR model bit-exactly.
- Generated CUT vs its BALANCED netlist on two instances, same SEED -> identical signature; inject a single stuck-at on cut_out[7] -> signatures differ.
- Abort at vec_idx=100 -> state IDLE next cycle, done=0, vec_idx=100; a subsequent start -> full sweep, vec_idx=2048.
- pause held 50 cycles during SETTLE and during CAPTURE -> total sweep time +50 cycles each, signature unchanged vs unpaused run.
- With CCG_SWEEP_GOLDEN_CMP_EN, golden_sig=correct -> pass=1, fail=0 at DONE; golden_sig^1 -> pass=0, fail=1; start clears both.
